// File: rtl/spc_pkg.sv
// ---------------------------------------------------------------------------
// spc_pkg
// Shared definitions for the streaming SPC leaf decoder.
//   LLR_W_DEF : default LLR width (two's complement)
//   state_e   : frame FSM states (S_ACC accumulating, S_OUT holding result)
//   sat_mag() : |LLR| with the most negative code saturated to 2^(w-1)-1
// ---------------------------------------------------------------------------
package spc_pkg;

  localparam int LLR_W_DEF = 6;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_e;

  // v is the sign-extended LLR, w its native width. The result always fits
  // in w-1 bits, so callers truncate it to their magnitude width.
  function automatic int sat_mag(input int v, input int w);
    int lim;
    lim = (1 << (w - 1)) - 1;
    if (v < 0) begin
      return (v < -lim) ? lim : -v;
    end
    return v;
  endfunction

endpackage

// File: rtl/spc_stream_dec_if.sv
// ---------------------------------------------------------------------------
// spc_stream_dec_if
// Input-beat and output-frame handshake bundle of spc_stream_dec.
//   in_valid/in_ready/in_llr    : LLR beats, earliest LLR in the MSBs
//   out_valid/out_ready/out_bits: decoded frame, bit k at out_bits[N-1-k]
//   par_err                     : per sub-code odd hard parity (SPC_PARERR_EN)
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; the producer keeps its payload stable while valid is high and
// ready is low, and ready never depends combinationally on valid.
// Modports: slave = decoder side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface spc_stream_dec_if
  import spc_pkg::*;
#(
  parameter int LLR_W = LLR_W_DEF,
  parameter int N     = 8,
  parameter int P     = 2,
  parameter int LANES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*LLR_W-1:0] in_llr;
  logic                   out_valid;
  logic                   out_ready;
  logic [N-1:0]           out_bits;
`ifdef SPC_PARERR_EN
  logic [P-1:0]           par_err;
`endif

  modport slave (
    input  in_valid, in_llr, out_ready,
    output in_ready, out_valid, out_bits
`ifdef SPC_PARERR_EN
    , output par_err
`endif
  );

  modport master (
    output in_valid, in_llr, out_ready,
    input  in_ready, out_valid, out_bits
`ifdef SPC_PARERR_EN
    , input par_err
`endif
  );
endinterface

// File: rtl/spc_sub_track.sv
// ---------------------------------------------------------------------------
// spc_sub_track
// Running state of one interleaved SPC sub-code: hard-bit parity, minimum
// magnitude and the output-bit position of that minimum.
// Ports:
//   clk, rst        : clock, async active-high reset
//   clr_i           : synchronous clear of all accumulators
//   upd_i           : a beat is accepted; fold hard_i/mag_i/pos_i in
//   first_i         : this beat holds position 0 of the sub-code
//   hard_i/mag_i/pos_i : this sub-code's lanes of the beat, index order
//                       (element 0 = earliest LLR)
//   par_o, min_pos_o: state with the current beat folded in (combinational)
// ---------------------------------------------------------------------------
module spc_sub_track #(
  parameter int MAG_W = 5,
  parameter int IDX_W = 3,
  parameter int LPB   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        upd_i,
  input  logic                        first_i,
  input  logic [LPB-1:0]              hard_i,
  input  logic [LPB-1:0][MAG_W-1:0]   mag_i,
  input  logic [LPB-1:0][IDX_W-1:0]   pos_i,
  output logic                        par_o,
  output logic [IDX_W-1:0]            min_pos_o
);
  logic             par_q, par_d;
  logic [MAG_W-1:0] min_q, min_d;
  logic [IDX_W-1:0] pos_q, pos_d;

  // Lanes are visited in index order and only a strictly smaller magnitude
  // wins, so ties keep the earliest LLR.
  always_comb begin
    par_d = par_q;
    min_d = min_q;
    pos_d = pos_q;
    for (int j = 0; j < LPB; j++) begin
      par_d = par_d ^ hard_i[j];
      if ((first_i && (j == 0)) || (mag_i[j] < min_d)) begin
        min_d = mag_i[j];
        pos_d = pos_i[j];
      end
    end
  end

  assign par_o     = par_d;
  assign min_pos_o = pos_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
      min_q <= '0;
      pos_q <= '0;
    end else if (clr_i) begin
      par_q <= 1'b0;
      min_q <= '0;
      pos_q <= '0;
    end else if (upd_i) begin
      par_q <= par_d;
      min_q <= min_d;
      pos_q <= pos_d;
    end
  end
endmodule

// File: rtl/spc_stream_dec.sv
// ---------------------------------------------------------------------------
// spc_stream_dec
// Streaming single-parity-check leaf decoder (Wagner rule). A frame of N LLRs
// arrives over N/LANES beats; LLR k belongs to sub-code k mod P. Each
// sub-code with odd hard parity has its least-reliable bit flipped, and the
// N decided bits are presented in one output beat.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : spc_stream_dec_if.slave (in_*, out_*, par_err)
//   state_o  : current FSM state, for observation
// Configuration macro: SPC_PARERR_EN adds the par_err register/port.
// Constraints: N % LANES == 0, LANES % P == 0, N/P >= 2.
// ---------------------------------------------------------------------------
module spc_stream_dec
  import spc_pkg::*;
#(
  parameter int LLR_W = LLR_W_DEF,
  parameter int N     = 8,
  parameter int P     = 2,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  spc_stream_dec_if.slave  bus,
  output state_e           state_o
);
  localparam int NB     = N / LANES;
  localparam int LPB    = LANES / P;
  localparam int MAG_W  = LLR_W - 1;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q;
  logic [N-1:0]      hard_q, hard_d;
  logic [N-1:0]      out_bits_q, res_d;

  logic in_fire, out_fire, last_beat;

  logic [LANES-1:0] lane_hard;
  logic [MAG_W-1:0] lane_mag [LANES];
  logic [IDX_W-1:0] lane_pos [LANES];

  logic [P-1:0]     sub_par;
  logic [IDX_W-1:0] sub_pos [P];

  assign bus.in_ready  = (state_q == S_ACC);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_bits  = out_bits_q;
  assign state_o       = state_q;

  assign in_fire   = bus.in_valid & (state_q == S_ACC);
  assign out_fire  = bus.out_ready & (state_q == S_OUT);
  assign last_beat = (beat_q == BEAT_W'(NB - 1));

  // Lane decode. lane_pos is the out_bits position of LLR k (N-1-k), so
  // downstream logic never needs to reverse indices.
  always_comb begin
    logic [LLR_W-1:0] llr;
    llr = '0;
    for (int l = 0; l < LANES; l++) begin
      llr          = bus.in_llr[(LANES-1-l)*LLR_W +: LLR_W];
      lane_hard[l] = llr[LLR_W-1];
      lane_mag[l]  = MAG_W'(sat_mag(int'($signed(llr)), LLR_W));
      lane_pos[l]  = IDX_W'(N - 1 - (int'(beat_q) * LANES + l));
    end
  end

  for (genvar s = 0; s < P; s++) begin : g_sub
    logic [LPB-1:0]            h;
    logic [LPB-1:0][MAG_W-1:0] m;
    logic [LPB-1:0][IDX_W-1:0] x;

    // Sub-code s owns lanes s, s+P, s+2P, ... of every beat.
    always_comb begin
      for (int j = 0; j < LPB; j++) begin
        h[j] = lane_hard[s + j*P];
        m[j] = lane_mag[s + j*P];
        x[j] = lane_pos[s + j*P];
      end
    end

    spc_sub_track #(
      .MAG_W(MAG_W),
      .IDX_W(IDX_W),
      .LPB  (LPB)
    ) u_track (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (out_fire),
      .upd_i    (in_fire),
      .first_i  (beat_q == '0),
      .hard_i   (h),
      .mag_i    (m),
      .pos_i    (x),
      .par_o    (sub_par[s]),
      .min_pos_o(sub_pos[s])
    );
  end

  // Hard bits with the current beat merged, then the Wagner flips.
  always_comb begin
    hard_d = hard_q;
    for (int l = 0; l < LANES; l++) begin
      hard_d[lane_pos[l]] = lane_hard[l];
    end
    res_d = hard_d;
    for (int s = 0; s < P; s++) begin
      if (sub_par[s]) begin
        res_d[sub_pos[s]] = ~res_d[sub_pos[s]];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (in_fire && last_beat) state_d = S_OUT;
      S_OUT:   if (bus.out_ready)        state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_ACC;
      beat_q     <= '0;
      hard_q     <= '0;
      out_bits_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        hard_q <= hard_d;
        beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
        if (last_beat) out_bits_q <= res_d;
      end
      if (out_fire) hard_q <= '0;
    end
  end

`ifdef SPC_PARERR_EN
  logic [P-1:0] par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= '0;
    end else if (in_fire && last_beat) begin
      par_err_q <= sub_par;
    end
  end

  assign bus.par_err = par_err_q;
`endif
endmodule

// File: tb/tb_spc_stream_dec.sv
module tb_spc_stream_dec;
  import spc_pkg::*;

  localparam int LLR_W = 6;
  localparam int N     = 8;
  localparam int P     = 2;
  localparam int LANES = 4;
  localparam int FW    = N * LLR_W;
  localparam int BW    = LANES * LLR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spc_stream_dec_if #(.LLR_W(LLR_W), .N(N), .P(P), .LANES(LANES)) bus ();
  state_e dbg_state;

  spc_stream_dec #(.LLR_W(LLR_W), .N(N), .P(P), .LANES(LANES)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .state_o(dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];
`ifdef SPC_PARERR_EN
  logic [P-1:0] exp_par_q[$];
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: Wagner decoding written straight from the rules on whole frames.
  function automatic void ref_decode(input logic [FW-1:0] fr, output logic [N-1:0] bits,
                                     output logic [P-1:0] par);
    int v[N];
    logic [LLR_W-1:0] raw;
    int best, bm, m;
    logic p;
    bits = '0;
    for (int k = 0; k < N; k++) begin
      raw = fr[FW-1-LLR_W*k -: LLR_W];
      v[k] = int'($signed(raw));
      bits[N-1-k] = (v[k] < 0);
    end
    for (int s = 0; s < P; s++) begin
      p = 1'b0; best = -1; bm = 0;
      for (int k = s; k < N; k += P) begin
        p = p ^ (v[k] < 0);
        m = (v[k] < 0) ? ((v[k] == -(1 << (LLR_W-1))) ? (1 << (LLR_W-1)) - 1 : -v[k]) : v[k];
        if (best < 0 || m < bm) begin best = k; bm = m; end
      end
      par[s] = p;
      if (p) bits[N-1-best] = ~bits[N-1-best];
    end
  endfunction

  function automatic logic [FW-1:0] mk(input int a, b, c, d, e, f, g, h);
    return {6'(a), 6'(b), 6'(c), 6'(d), 6'(e), 6'(f), 6'(g), 6'(h)};
  endfunction

  task automatic push_exp(input logic [N-1:0] bits, input logic [P-1:0] par);
    exp_q.push_back(bits);
`ifdef SPC_PARERR_EN
    exp_par_q.push_back(par);
`else
    if (par === 'x) $display("note: unknown parity");
`endif
  endtask

  task automatic push_model(input logic [FW-1:0] fr);
    logic [N-1:0] b;
    logic [P-1:0] p;
    ref_decode(fr, b, p);
    push_exp(b, p);
  endtask

  // ---------------- drivers (drive #1 after posedge) ----------------
  task automatic send_beat(input logic [BW-1:0] d);
    int cnt = 0;
    bus.in_valid = 1'b1;
    bus.in_llr   = d;
    while (!bus.in_ready && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    if (!bus.in_ready) begin
      n_checks++; n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic get_frame(input string name);
    int cnt = 0;
    logic [N-1:0] eb;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    eb = exp_q.pop_front();
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_bits"}, 32'(bus.out_bits), 32'(eb));
`ifdef SPC_PARERR_EN
    check({name, "_par"}, 32'(bus.par_err), 32'(exp_par_q.pop_front()));
`endif
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({name, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic send_frame(input logic [FW-1:0] fr);
    send_beat(fr[FW-1 -: BW]);
    send_beat(fr[BW-1:0]);
    check("latency", 32'(bus.out_valid), 32'd1);
  endtask

  typedef struct packed {
    logic [FW-1:0] fr;
    logic [N-1:0]  bits;
    logic [P-1:0]  par;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [FW-1:0] fa, fb, fx;
    logic [N-1:0]  held;
    logic [63:0]   r;

    vecs[0] = '{fr: mk(5, -3, 7, 2, -1, 4, 6, 8),        bits: 8'h50, par: 2'b11};
    vecs[1] = '{fr: mk(3, 1, 3, 2, -3, 3, 3, 4),         bits: 8'h88, par: 2'b01};
    vecs[2] = '{fr: mk(-32, 5, -31, 5, 31, 5, 31, 5),    bits: 8'hA0, par: 2'b00};
    vecs[3] = '{fr: mk(1, 2, 3, 4, 5, 6, 7, 8),          bits: 8'h00, par: 2'b00};
    vecs[4] = '{fr: mk(-1, -1, -1, -1, -1, -1, -1, -1),  bits: 8'hFF, par: 2'b00};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_llr = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bits", 32'(bus.out_bits), 32'd0);
`ifdef SPC_PARERR_EN
    check("rst_par_err", 32'(bus.par_err), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      push_exp(vecs[i].bits, vecs[i].par);
      send_frame(vecs[i].fr);
      get_frame($sformatf("vec%0d", i));
    end

    // Backpressure: hold 3 cycles with a competing beat offered
    fx = mk(-4, 9, 2, -7, 3, -12, 1, 6);
    push_exp(vecs[0].bits, vecs[0].par);
    send_frame(vecs[0].fr);
    held = bus.out_bits;
    bus.in_valid = 1'b1;
    bus.in_llr = fx[FW-1 -: BW];
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_bits", 32'(bus.out_bits), 32'(vecs[0].bits));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_bits_at_release", 32'(held), 32'(exp_q.pop_front()));
`ifdef SPC_PARERR_EN
    void'(exp_par_q.pop_front());
`endif
    check("bp_released", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;  // pending beat 0 of fx accepted here
    push_model(fx);
    send_beat(fx[BW-1:0]);
    check("bp_next_latency", 32'(bus.out_valid), 32'd1);
    get_frame("bp_next");

    // Reset mid-frame
    fa = mk(-9, -9, -9, -9, 2, 2, 2, 2);
    fb = mk(6, -2, 4, 3, -8, 1, 5, -10);
    send_beat(fa[FW-1 -: BW]);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    push_model(fb);
    send_frame(fb);
    get_frame("mid_rst");

    // Gapped input: 1,0,0,1
    push_model(vecs[1].fr);
    send_beat(vecs[1].fr[FW-1 -: BW]);
    repeat (2) @(posedge clk);
    #1;
    check("gap_not_valid", 32'(bus.out_valid), 32'd0);
    send_beat(vecs[1].fr[BW-1:0]);
    check("gap_latency", 32'(bus.out_valid), 32'd1);
    get_frame("gap");

    // Randomized frames with gaps and delayed consumer
    for (int f = 0; f < 40; f++) begin
      r = {$urandom, $urandom};
      fa = r[FW-1:0];
      if (f % 5 == 0) fa[FW-1 -: LLR_W] = 6'h20;  // force most negative code
      push_model(fa);
      send_beat(fa[FW-1 -: BW]);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_beat(fa[BW-1:0]);
      check("rnd_latency", 32'(bus.out_valid), 32'd1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      get_frame($sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
